// File: rtl/speed_scheduler_if.sv
// Game-control bundle between the scheduler, the button/collision
// logic, the variable timer and the LED animator.
interface speed_scheduler_if #(
  parameter int SCORE_WIDTH = 8
);
  logic                   start;
  logic                   pause;
  logic                   collision;
  logic                   timeout_pulse;
  logic                   var_timer_enable;
  logic [1:0]             speed;
  logic                   step_pulse;
  logic [SCORE_WIDTH-1:0] score;
  logic                   game_over;

  modport master (
    input  start, pause, collision, timeout_pulse,
    output var_timer_enable, speed, step_pulse,
    output score, game_over
  );

  modport slave (
    output start, pause, collision, timeout_pulse,
    input  var_timer_enable, speed, step_pulse,
    input  score, game_over
  );
endinterface

// File: rtl/speed_scheduler.sv
// Game-flow FSM: turns timer timeouts into animation steps, keeps the
// survival score and ramps the timer speed every few steps.
module speed_scheduler #(
  parameter int TICKS_PER_LEVEL = 8,
  parameter int MAX_SPEED       = 3,
  parameter int SCORE_WIDTH     = 8
) (
  input  logic clk,
  input  logic rst,
  speed_scheduler_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] OVER   = 2'd3;

  localparam logic [7:0] LVL_LAST = 8'(TICKS_PER_LEVEL - 1);
  localparam logic [1:0] SPD_MAX  = 2'(MAX_SPEED);
  localparam logic [SCORE_WIDTH-1:0] ONE = SCORE_WIDTH'(1);

  logic [1:0]             state;
  logic [1:0]             state_nx;
  logic [7:0]             lvl;
  logic [1:0]             speed;
  logic [SCORE_WIDTH-1:0] score;
  logic                   step;
  logic                   enable;
  logic                   over;
  logic                   restart;
  logic                   take;

  // Priority in RUN: collision, then pause, then timeout.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          restart  = 1'b1;
        end
      end
      RUN: begin
        if (bus.collision)
          state_nx = OVER;
        else if (bus.pause)
          state_nx = PAUSED;
        else if (bus.timeout_pulse)
          take = 1'b1;
      end
      PAUSED: begin
        if (bus.pause || bus.start)
          state_nx = RUN;
      end
      OVER: begin
        if (bus.start) begin
          state_nx = RUN;
          restart  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lvl    <= '0;
      speed  <= '0;
      score  <= '0;
      step   <= 1'b0;
      enable <= 1'b0;
      over   <= 1'b0;
    end else begin
      state  <= state_nx;
      enable <= (state_nx == RUN);
      over   <= (state_nx == OVER);
      step   <= take;
      if (restart) begin
        score <= '0;
        speed <= '0;
        lvl   <= '0;
      end else if (take) begin
        if (score != '1)
          score <= score + ONE;
        if (lvl == LVL_LAST) begin
          lvl <= '0;
          if (speed < SPD_MAX)
            speed <= speed + 2'd1;
        end else begin
          lvl <= lvl + 8'd1;
        end
      end
    end
  end

  assign bus.var_timer_enable = enable;
  assign bus.speed            = speed;
  assign bus.step_pulse       = step;
  assign bus.score            = score;
  assign bus.game_over        = over;
endmodule

// File: tb/tb_speed_scheduler.sv
// Bench for speed_scheduler: two parameterisations driven in lockstep
// and compared every cycle against a step-count game model.
module tb_speed_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  speed_scheduler_if #(.SCORE_WIDTH(8)) b0();
  speed_scheduler_if #(.SCORE_WIDTH(4)) b1();

  speed_scheduler #(
    .TICKS_PER_LEVEL(8), .MAX_SPEED(3), .SCORE_WIDTH(8)
  ) dut0 (.clk(clk), .rst(rst), .bus(b0));

  speed_scheduler #(
    .TICKS_PER_LEVEL(3), .MAX_SPEED(2), .SCORE_WIDTH(4)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_OVER} mode_t;
  mode_t mode [2];
  int    nsteps [2];
  bit    stp [2];
  int    total = 0;
  int    bad = 0;

  function automatic int tpl(int i);
    return (i == 0) ? 8 : 3;
  endfunction
  function automatic int mspd(int i);
    return (i == 0) ? 3 : 2;
  endfunction
  function automatic int swid(int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int exp_score(int i);
    int mx;
    mx = (1 << swid(i)) - 1;
    return (nsteps[i] > mx) ? mx : nsteps[i];
  endfunction
  function automatic int exp_speed(int i);
    int v;
    v = nsteps[i] / tpl(i);
    return (v > mspd(i)) ? mspd(i) : v;
  endfunction

  task automatic chk(string tag, logic [31:0] got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic drive(bit s, bit p, bit c, bit t);
    b0.start = s; b0.pause = p;
    b0.collision = c; b0.timeout_pulse = t;
    b1.start = s; b1.pause = p;
    b1.collision = c; b1.timeout_pulse = t;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE;
      nsteps[i] = 0;
      stp[i] = 1'b0;
    end
  endtask

  task automatic model_step(bit s, bit p, bit c, bit t);
    for (int i = 0; i < 2; i++) begin
      stp[i] = 1'b0;
      case (mode[i])
        M_IDLE:
          if (s) begin mode[i] = M_RUN; nsteps[i] = 0; end
        M_RUN:
          if (c) mode[i] = M_OVER;
          else if (p) mode[i] = M_PAUSE;
          else if (t) begin nsteps[i]++; stp[i] = 1'b1; end
        M_PAUSE:
          if (p || s) mode[i] = M_RUN;
        default:
          if (s) begin mode[i] = M_RUN; nsteps[i] = 0; end
      endcase
    end
  endtask

  task automatic check_all();
    chk("en0", 32'(b0.var_timer_enable), int'(mode[0] == M_RUN));
    chk("over0", 32'(b0.game_over), int'(mode[0] == M_OVER));
    chk("step0", 32'(b0.step_pulse), int'(stp[0]));
    chk("score0", 32'(b0.score), exp_score(0));
    chk("speed0", 32'(b0.speed), exp_speed(0));
    chk("en1", 32'(b1.var_timer_enable), int'(mode[1] == M_RUN));
    chk("over1", 32'(b1.game_over), int'(mode[1] == M_OVER));
    chk("step1", 32'(b1.step_pulse), int'(stp[1]));
    chk("score1", 32'(b1.score), exp_score(1));
    chk("speed1", 32'(b1.speed), exp_speed(1));
  endtask

  task automatic cyc(bit s, bit p, bit c, bit t);
    @(negedge clk);
    drive(s, p, c, t);
    @(posedge clk);
    model_step(s, p, c, t);
    #1;
    check_all();
  endtask

  task automatic run_steps(int n);
    repeat (n) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
  endtask

  // Reset lands between edges; outputs must clear before any clock.
  task automatic areset();
    @(negedge clk);
    drive(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    cyc(0, 1, 1, 1);
    cyc(1, 0, 0, 0);
    chk("start_en", 32'(b0.var_timer_enable), 1);
    run_steps(8);
    chk("lvl8_speed", 32'(b0.speed), 1);
    chk("lvl8_score", 32'(b0.score), 8);
    run_steps(24);
    chk("s32_speed", 32'(b0.speed), 3);
    run_steps(8);
    chk("s40_score", 32'(b0.score), 40);
    chk("s40_speed", 32'(b0.speed), 3);
    chk("sat_score", 32'(b1.score), 15);

    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    run_steps(5);
    cyc(0, 0, 1, 1);
    chk("col_score", 32'(b0.score), 5);
    chk("col_step", 32'(b0.step_pulse), 0);
    chk("col_over", 32'(b0.game_over), 1);
    chk("col_en", 32'(b0.var_timer_enable), 0);
    cyc(0, 0, 0, 0);
    chk("col_nostep", 32'(b0.step_pulse), 0);
    cyc(1, 0, 0, 0);
    chk("restart_score", 32'(b0.score), 0);
    chk("restart_over", 32'(b0.game_over), 0);

    run_steps(3);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    chk("pause_en", 32'(b0.var_timer_enable), 0);
    cyc(0, 1, 0, 0);
    chk("resume_score", 32'(b0.score), 3);
    run_steps(5);
    chk("resume_speed", 32'(b0.speed), 1);

    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    run_steps(12);
    chk("pre_rst_score", 32'(b0.score), 12);
    areset();
    chk("rst_score", 32'(b0.score), 0);
    cyc(1, 0, 0, 0);
    chk("post_rst_en", 32'(b0.var_timer_enable), 1);

    repeat (3000) begin
      if ($urandom % 200 == 0)
        areset();
      else
        cyc($urandom % 16 == 0, $urandom % 12 == 0,
            $urandom % 40 == 0, $urandom % 3 == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
